// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage:
//   - base opcode constants
//   - ALU op encodings, op = {alt_bit, funct3}
//   - immediate-format enum and an immediate extraction helper
//   - the decoded-field bundle carried from the decoder to the output register
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int unsigned OP_W = 4;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU op encodings
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Decoded fields of one instruction; imm is the 32-bit sign-extended value,
  // widened to XLEN at the stage output.
  typedef struct packed {
    logic [31:0]     imm;
    logic [OP_W-1:0] op;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic            imm_b;
    logic            wb;
    logic            mem;
    logic            mem_read;
    logic            branch;
    logic            jump;
    logic [2:0]      cmp;
    logic            illegal;
  } dec_fields_t;

  // Build the 32-bit sign-extended immediate for a given format.
  function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// -----------------------------------------------------------------------------
// rv_decode_comb
// Pure combinational decode of one RV32I instruction word.
// Ports:
//   instr_i   in   32            instruction word
//   fields_o  out  dec_fields_t  decoded fields (all controls zero when illegal)
// Register fields ra/rb/rd are always the raw instruction fields; for illegal
// encodings every control, the op and the immediate are forced to zero so a
// bad word can never cause a write, memory access or redirect downstream.
// -----------------------------------------------------------------------------
module rv_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_fields_t fields_o
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rd_s;
  imm_fmt_e        fmt_s;
  logic [OP_W-1:0] op_s;
  logic            imm_b_s;
  logic            wb_s;
  logic            mem_s;
  logic            mem_read_s;
  logic            branch_s;
  logic            jump_s;
  logic [2:0]      cmp_s;
  logic            illegal_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign rd_s     = instr_i[11:7];

  // Per-opcode classification: immediate format, ALU op and control flags.
  always_comb begin
    fmt_s      = IMM_NONE;
    op_s       = ALU_ADD;
    imm_b_s    = 1'b0;
    wb_s       = 1'b0;
    mem_s      = 1'b0;
    mem_read_s = 1'b0;
    branch_s   = 1'b0;
    jump_s     = 1'b0;
    cmp_s      = 3'b000;
    illegal_s  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        op_s = {funct7_s[5], funct3_s};
        wb_s = 1'b1;
        // Only funct7 0x00 (any funct3) and 0x20 with SUB/SRA are defined
        if (funct7_s == 7'h00) begin
          illegal_s = 1'b0;
        end else if ((funct7_s == 7'h20) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          illegal_s = 1'b0;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        fmt_s   = IMM_I;
        // Alt bit only selects SRAI vs SRLI; for other funct3 it is immediate data
        op_s    = {(funct3_s == 3'b101) ? funct7_s[5] : 1'b0, funct3_s};
        imm_b_s = 1'b1;
        wb_s    = 1'b1;
      end
      OPC_LOAD: begin
        fmt_s      = IMM_I;
        imm_b_s    = 1'b1;
        wb_s       = 1'b1;
        mem_s      = 1'b1;
        mem_read_s = 1'b1;
      end
      OPC_STORE: begin
        fmt_s   = IMM_S;
        imm_b_s = 1'b1;
        mem_s   = 1'b1;
      end
      OPC_BRANCH: begin
        fmt_s     = IMM_B;
        branch_s  = 1'b1;
        cmp_s     = funct3_s;
        illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_s   = IMM_U;
        imm_b_s = 1'b1;
        wb_s    = 1'b1;
      end
      OPC_JAL: begin
        fmt_s   = IMM_J;
        imm_b_s = 1'b1;
        wb_s    = 1'b1;
        jump_s  = 1'b1;
      end
      OPC_JALR: begin
        fmt_s   = IMM_I;
        imm_b_s = 1'b1;
        wb_s    = 1'b1;
        jump_s  = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Assemble the output bundle, squashing everything but the flag on illegal words.
  always_comb begin
    fields_o.ra = instr_i[19:15];
    fields_o.rb = instr_i[24:20];
    fields_o.rd = rd_s;
    if (illegal_s) begin
      fields_o.imm      = 32'h0000_0000;
      fields_o.op       = ALU_ADD;
      fields_o.imm_b    = 1'b0;
      fields_o.wb       = 1'b0;
      fields_o.mem      = 1'b0;
      fields_o.mem_read = 1'b0;
      fields_o.branch   = 1'b0;
      fields_o.jump     = 1'b0;
      fields_o.cmp      = 3'b000;
      fields_o.illegal  = 1'b1;
    end else begin
      fields_o.imm      = imm_extract(instr_i, fmt_s);
      fields_o.op       = op_s;
      fields_o.imm_b    = imm_b_s;
      fields_o.wb       = wb_s && (rd_s != 5'd0);  // x0 writes are dropped here
      fields_o.mem      = mem_s;
      fields_o.mem_read = mem_read_s;
      fields_o.branch   = branch_s;
      fields_o.jump     = jump_s;
      fields_o.cmp      = cmp_s;
      fields_o.illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Buffered, handshaked RV32I decode stage: a DEPTH-entry instruction queue
// feeding rv_decode_comb, whose result is captured in an output register.
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   flush_i                       drop queue and output register at next edge
//   fetch_valid_i/fetch_ready_o   fetch handshake; ready = queue not full
//   fetch_instr_i, fetch_pc_i     instruction word and its address
//   dec_valid_o/dec_ready_i       execute handshake
//   dec_pc_o, dec_imm_o           PC and sign-extended immediate
//   dec_op_o                      ALU op {alt_bit, funct3}
//   dec_ra_o/dec_rb_o/dec_rd_o    register indices
//   dec_imm_b_o, dec_wb_o, dec_mem_o, dec_mem_read_o,
//   dec_branch_o, dec_jump_o, dec_cmp_o, dec_illegal_o   control outputs
// Total buffering is DEPTH + 1 (queue plus output register). fetch_ready_o
// looks only at the queue count, so a same-cycle pop does not free a slot.
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_instr_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_imm_o,
  output logic [OP_W-1:0] dec_op_o,
  output logic [4:0]      dec_ra_o,
  output logic [4:0]      dec_rb_o,
  output logic [4:0]      dec_rd_o,
  output logic            dec_imm_b_o,
  output logic            dec_wb_o,
  output logic            dec_mem_o,
  output logic            dec_mem_read_o,
  output logic            dec_branch_o,
  output logic            dec_jump_o,
  output logic [2:0]      dec_cmp_o,
  output logic            dec_illegal_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  dec_fields_t     out_fields_q, out_fields_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            push_s;
  logic            pop_s;
  dec_fields_t     head_fields_s;

  rv_decode_comb u_dec (
    .instr_i  (instr_q[rd_ptr_q]),
    .fields_o (head_fields_s)
  );

  assign fetch_ready_o = (count_q != CNT_W'(DEPTH));

  // Handshake decisions and next-state for pointers, count and output register.
  always_comb begin
    push_s       = fetch_valid_i && fetch_ready_o && !flush_i;
    // Output register frees either when empty or when execute takes it now
    pop_s        = (count_q != {CNT_W{1'b0}}) && (!out_valid_q || dec_ready_i) && !flush_i;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_fields_d = out_fields_q;
    out_pc_d     = out_pc_q;
    if (flush_i) begin
      wr_ptr_d     = {PTR_W{1'b0}};
      rd_ptr_d     = {PTR_W{1'b0}};
      count_d      = {CNT_W{1'b0}};
      out_valid_d  = 1'b0;
      out_fields_d = '{default: '0};
      out_pc_d     = {XLEN{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop_s) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        out_valid_d  = 1'b1;
        out_fields_d = head_fields_s;
        out_pc_d     = pc_q[rd_ptr_q];
      end else if (dec_ready_i) begin
        // Consumed with nothing to replace it; stale fields are harmless
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Queue storage: write the accepted word at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= 32'h0000_0000;
        pc_q[i]    <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      instr_q[wr_ptr_q] <= fetch_instr_i;
      pc_q[wr_ptr_q]    <= fetch_pc_i;
    end
  end

  // Control state and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_fields_q <= '{default: '0};
      out_pc_q     <= {XLEN{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_fields_q <= out_fields_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign dec_valid_o    = out_valid_q;
  assign dec_pc_o       = out_pc_q;
  assign dec_imm_o      = XLEN'($signed(out_fields_q.imm));
  assign dec_op_o       = out_fields_q.op;
  assign dec_ra_o       = out_fields_q.ra;
  assign dec_rb_o       = out_fields_q.rb;
  assign dec_rd_o       = out_fields_q.rd;
  assign dec_imm_b_o    = out_fields_q.imm_b;
  assign dec_wb_o       = out_fields_q.wb;
  assign dec_mem_o      = out_fields_q.mem;
  assign dec_mem_read_o = out_fields_q.mem_read;
  assign dec_branch_o   = out_fields_q.branch;
  assign dec_jump_o     = out_fields_q.jump;
  assign dec_cmp_o      = out_fields_q.cmp;
  assign dec_illegal_o  = out_fields_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed vectors with known results,
// capacity/drain, flush and async reset scenarios, then random traffic, all
// compared against a transaction-level reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            fetch_valid = 1'b0;
  logic            fetch_ready;
  logic [31:0]     fetch_instr = 32'h0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            dec_valid;
  logic            dec_ready = 1'b0;
  logic [XLEN-1:0] dec_pc, dec_imm;
  logic [3:0]      dec_op;
  logic [4:0]      dec_ra, dec_rb, dec_rd;
  logic            dec_imm_b, dec_wb, dec_mem, dec_mem_read, dec_branch, dec_jump, dec_illegal;
  logic [2:0]      dec_cmp;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_instr_i(fetch_instr), .fetch_pc_i(fetch_pc),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_pc_o(dec_pc), .dec_imm_o(dec_imm), .dec_op_o(dec_op),
    .dec_ra_o(dec_ra), .dec_rb_o(dec_rb), .dec_rd_o(dec_rd),
    .dec_imm_b_o(dec_imm_b), .dec_wb_o(dec_wb), .dec_mem_o(dec_mem),
    .dec_mem_read_o(dec_mem_read), .dec_branch_o(dec_branch), .dec_jump_o(dec_jump),
    .dec_cmp_o(dec_cmp), .dec_illegal_o(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic [31:0] pc; } item_t;
  typedef struct packed { logic [31:0] imm; logic [3:0] op; logic [14:0] regs; logic [9:0] fl; } exp_t;

  // Reference model: every instruction accepted but not yet consumed, oldest
  // first; m_out says whether the oldest one is sitting in the output register.
  item_t pend[$];
  bit    m_out = 1'b0;
  int    tests = 0;
  int    fails = 0;

  logic [31:0] vec_w   [6] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'hFE208EE3, 32'h00000000, 32'h00002103};
  logic [3:0]  vec_op  [6] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [31:0] vec_imm [6] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0};
  // {imm_b, wb, mem, mem_read, branch, jump, cmp[2:0], illegal}
  logic [9:0]  vec_fl  [6] = '{10'b0100000000, 10'b0100000000, 10'b1100000000,
                               10'b0000100000, 10'b0000000001, 10'b1111000000};

  function automatic logic [9:0] dut_flags();
    return {dec_imm_b, dec_wb, dec_mem, dec_mem_read, dec_branch, dec_jump, dec_cmp, dec_illegal};
  endfunction

  // Expected decode of a word, straight from the RV32I format rules.
  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, ib, wb, mem, mr, br, jp;
    logic [2:0] cmp;
    int imm;
    logic [3:0] op;
    f3 = w[14:12]; f7 = w[31:25];
    ok = 1'b1; ib = 1'b0; wb = 1'b0; mem = 1'b0; mr = 1'b0; br = 1'b0; jp = 1'b0;
    cmp = 3'd0; imm = 0; op = 4'd0;
    case (w[6:0])
      7'h33: begin ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); op = {f7[5], f3}; wb = 1'b1; end
      7'h13: begin imm = int'($signed(w[31:20])); op = {(f3 == 3'd5) && w[30], f3}; ib = 1'b1; wb = 1'b1; end
      7'h03: begin imm = int'($signed(w[31:20])); mem = 1'b1; mr = 1'b1; wb = 1'b1; ib = 1'b1; end
      7'h23: begin imm = int'($signed({w[31:25], w[11:7]})); mem = 1'b1; ib = 1'b1; end
      7'h63: begin
        imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        br = 1'b1; cmp = f3; ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h37, 7'h17: begin imm = int'({w[31:12], 12'h000}); wb = 1'b1; ib = 1'b1; end
      7'h6F: begin imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); jp = 1'b1; wb = 1'b1; ib = 1'b1; end
      7'h67: begin imm = int'($signed(w[31:20])); jp = 1'b1; wb = 1'b1; ib = 1'b1; end
      default: ok = 1'b0;
    endcase
    e.regs = {w[19:15], w[24:20], w[11:7]};
    if (!ok) begin
      e.imm = 32'h0; e.op = 4'd0; e.fl = 10'b0000000001;
    end else begin
      e.imm = imm; e.op = op;
      e.fl = {ib, wb && (w[11:7] != 5'd0), mem, mr, br, jp, cmp, 1'b0};
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    check("dec_valid", dec_valid, m_out);
    check("fetch_ready", fetch_ready, (pend.size() - int'(m_out)) != DEPTH);
    if (m_out) begin
      e = model_decode(pend[0].w);
      check("pc", dec_pc, pend[0].pc);
      check("imm", dec_imm, e.imm);
      check("op", dec_op, e.op);
      check("regs", {dec_ra, dec_rb, dec_rd}, e.regs);
      check("flags", dut_flags(), e.fl);
    end
  endtask

  // One clock: advance the model with the pre-edge handshake, then check #1 after the edge.
  task automatic tick();
    int qc;
    bit acc, pop, cons;
    item_t it;
    qc   = pend.size() - int'(m_out);
    acc  = fetch_valid && (qc != DEPTH);
    pop  = (qc > 0) && (!m_out || dec_ready);
    cons = m_out && dec_ready;
    it.w = fetch_instr; it.pc = fetch_pc;
    @(posedge clk);
    if (!rst_n || flush) begin
      pend.delete(); m_out = 1'b0;
    end else begin
      if (cons) void'(pend.pop_front());
      m_out = pop ? 1'b1 : (cons ? 1'b0 : m_out);
      if (acc) pend.push_back(it);
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h33;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int acc_cnt;

    // Reset state
    tick(); tick();
    check("rst_pc_imm", {dec_pc, dec_imm}, 64'h0);
    check("rst_ctl", {dec_op, dec_ra, dec_rb, dec_rd, dut_flags()}, 64'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", fetch_ready, 1'b1);

    // Directed decode vectors with one-edge latency
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1; fetch_instr = vec_w[i]; fetch_pc = 32'h100 + 32'(4 * i); dec_ready = 1'b0;
      tick();
      fetch_valid = 1'b0;
      check("lat_edge_k", dec_valid, 1'b0);
      tick();
      check("lat_edge_k1", dec_valid, 1'b1);
      check("vec_op", dec_op, vec_op[i]);
      check("vec_imm", dec_imm, vec_imm[i]);
      check("vec_flags", dut_flags(), vec_fl[i]);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
    end

    // Capacity: DEPTH+1 accepted while execute stalls, then in-order drain
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1; fetch_instr = 32'h00000033 | (32'(i + 1) << 7); fetch_pc = 32'h2000 + 32'(4 * i);
      if (fetch_ready) acc_cnt++;
      tick();
    end
    fetch_valid = 1'b0;
    check("cap_accepts", acc_cnt, 5);
    check("cap_ready_low", fetch_ready, 1'b0);
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", dec_valid, 1'b1);
      check("drain_pc", dec_pc, 32'h2000 + 32'(4 * i));
      tick();
    end
    check("drain_empty", dec_valid, 1'b0);

    // Flush with three queued, one in output, and a push in the same cycle
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1; fetch_instr = 32'h00100093; fetch_pc = 32'h3000 + 32'(4 * i);
      tick();
    end
    fetch_instr = 32'h00500113; fetch_pc = 32'h3FF0; flush = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    check("flush_valid", dec_valid, 1'b0);
    check("flush_ready", fetch_ready, 1'b1);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_ghost", dec_valid, 1'b0);
    end

    // Async reset between edges during traffic
    for (int i = 0; i < 20; i++) begin
      fetch_valid = 1'b1; fetch_instr = rand_word(); fetch_pc = $urandom & 32'hFFFFFFFC;
      dec_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    pend.delete(); m_out = 1'b0;
    check("arst_valid", dec_valid, 1'b0);
    check("arst_pc_imm", {dec_pc, dec_imm}, 64'h0);
    check("arst_ctl", {dec_op, dec_ra, dec_rb, dec_rd, dut_flags()}, 64'h0);
    check("arst_ready", fetch_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      fetch_valid = ($urandom_range(0, 2) != 0);
      fetch_instr = rand_word();
      fetch_pc    = $urandom & 32'hFFFFFFFC;
      dec_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0; fetch_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
